// File: rtl/otter_mmio_logger.sv
// otter_mmio_logger: OTTER IO-bus responder with a result FIFO, stream drain, sticky DONE and TOTAL count.
// Optional feature macro MMIO_LOGGER_TIMESTAMP_EN stamps each entry with a free-running cycle counter.
module otter_mmio_logger #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_iobus_re,
  input  logic        i_iobus_we,
  input  logic [3:0]  i_iobus_sel,
  input  logic [31:0] i_iobus_addr,
  input  logic [31:0] i_iobus_wdata,
  output logic [31:0] o_iobus_data,
  output logic        o_hit,
  output logic        o_log_valid,
  output logic [31:0] o_log_data,
`ifdef MMIO_LOGGER_TIMESTAMP_EN
  output logic [31:0] o_log_time,
`endif
  input  logic        i_log_ready,
  output logic        o_overflow,
  output logic        o_done,
  output logic [31:0] o_done_code
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
`ifdef MMIO_LOGGER_TIMESTAMP_EN
  localparam int unsigned EW = 64;
`else
  localparam int unsigned EW = 32;
`endif

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DONE   = 2'd2;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] count;
  logic [PW-1:0] count_next;
  logic [1:0]    reg_sel;
  logic [1:0]    unused_addr;
  logic          in_window;
  logic          wr_any;
  logic          data_wr;
  logic          status_wr;
  logic          done_wr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [31:0]   merged;
  logic [31:0]   rd_value;
  logic [31:0]   last_reg;
  logic [EW-1:0] entry;
  logic [EW-1:0] head_next;

  // Address decode; the low two address bits never select anything.
  assign reg_sel     = i_iobus_addr[3:2];
  assign unused_addr = i_iobus_addr[1:0];
  assign in_window   = (i_iobus_addr[31:4] == BASE_ADDR[31:4]);
  assign o_hit       = (i_iobus_re | i_iobus_we) & in_window;
  assign wr_any      = i_iobus_we & in_window & (i_iobus_sel != 4'b0000);
  assign data_wr     = wr_any & (reg_sel == REG_DATA);
  assign status_wr   = wr_any & (reg_sel == REG_STATUS);
  assign done_wr     = wr_any & (reg_sel == REG_DONE);

  // Byte-lane merge: disabled lanes read as zero.
  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      if (i_iobus_sel[i]) merged[8*i +: 8] = i_iobus_wdata[8*i +: 8];
    end
  end

  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == PW'(DEPTH));
  assign empty       = (count == '0);
  assign pop         = o_log_valid & i_log_ready;
  assign push        = data_wr & (~full | pop);
  assign rd_ptr_next = rd_ptr + PW'(pop);
  assign wr_ptr_next = wr_ptr + PW'(push);
  assign count_next  = wr_ptr_next - rd_ptr_next;

`ifdef MMIO_LOGGER_TIMESTAMP_EN
  logic [31:0] timer;

  assign entry    = {timer, merged};
  assign last_reg = timer;

  always_ff @(posedge clk) begin
    if (rst) timer <= '0;
    else     timer <= timer + 32'd1;
  end
`else
  logic [31:0] total;

  assign entry    = merged;
  assign last_reg = total;

  // TOTAL counts every DATA write, dropped or not.
  always_ff @(posedge clk) begin
    if (rst)          total <= '0;
    else if (data_wr) total <= total + 32'd1;
  end
`endif

  // Next head: the word being pushed when it becomes the only entry, else storage.
  always_comb begin
    head_next = mem[rd_ptr_next[AW-1:0]];
    if (push && (count_next == PW'(1))) head_next = entry;
  end

  always_comb begin
    rd_value = '0;
    case (reg_sel)
      REG_DATA:   rd_value = 32'(count);
      REG_STATUS: rd_value = {16'(count), 11'b0, o_overflow, full, empty, o_done, 1'b0};
      REG_DONE:   rd_value = o_done_code;
      default:    rd_value = last_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      o_iobus_data <= '0;
      o_log_valid  <= 1'b0;
      o_log_data   <= '0;
`ifdef MMIO_LOGGER_TIMESTAMP_EN
      o_log_time   <= '0;
`endif
      o_overflow   <= 1'b0;
      o_done       <= 1'b0;
      o_done_code  <= '0;
    end else begin
      rd_ptr       <= rd_ptr_next;
      wr_ptr       <= wr_ptr_next;
      o_iobus_data <= (i_iobus_re & in_window) ? rd_value : '0;
      o_log_valid  <= (count_next != '0);
      // Empty stream keeps presenting the last head word.
      if (count_next != '0) begin
        o_log_data <= head_next[31:0];
`ifdef MMIO_LOGGER_TIMESTAMP_EN
        o_log_time <= head_next[63:32];
`endif
      end
      if (data_wr && full && !pop)              o_overflow <= 1'b1;
      else if (status_wr && i_iobus_wdata[0])   o_overflow <= 1'b0;
      if (done_wr) begin
        o_done      <= 1'b1;
        o_done_code <= merged;
      end
    end
  end

endmodule

// File: tb/tb_otter_mmio_logger.sv
// Testbench for otter_mmio_logger: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_otter_mmio_logger;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        re;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] o_iobus_data;
  logic        o_hit;
  logic        o_log_valid;
  logic [31:0] o_log_data;
  logic        o_overflow;
  logic        o_done;
  logic [31:0] o_done_code;

  always #5 clk = ~clk;

  otter_mmio_logger #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_iobus_re(re), .i_iobus_we(we), .i_iobus_sel(sel),
    .i_iobus_addr(addr), .i_iobus_wdata(wdata),
    .o_iobus_data(o_iobus_data), .o_hit(o_hit),
    .o_log_valid(o_log_valid), .o_log_data(o_log_data), .i_log_ready(ready),
    .o_overflow(o_overflow), .o_done(o_done), .o_done_code(o_done_code)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] q[$];
  logic        m_ovf;
  logic        m_done;
  logic [31:0] m_code;
  logic [31:0] m_total;
  logic [31:0] m_head;
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return d & mask;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_done = 0; m_code = 0; m_total = 0; m_head = 0; m_rd = 0;
  endtask

  task automatic model_step(input logic r, input logic w, input logic [3:0] s,
                            input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bit inw;
    int n;
    bit popped;
    inw = (a[31:4] == BASE[31:4]);
    n = q.size();
    m_rd = 0;
    if (r && inw) begin
      case (a[3:2])
        2'd0: m_rd = 32'(n);
        2'd1: m_rd = {16'(n), 11'b0, m_ovf, n == DEPTH, n == 0, m_done, 1'b0};
        2'd2: m_rd = m_code;
        default: m_rd = m_total;
      endcase
    end
    popped = rdy && (n > 0);
    if (popped) void'(q.pop_front());
    if (w && inw && s != 4'b0000) begin
      case (a[3:2])
        2'd0: begin
          m_total = m_total + 1;
          if (n < DEPTH || popped) q.push_back(merge(d, s));
          else m_ovf = 1;
        end
        2'd1: if (d[0]) m_ovf = 0;
        2'd2: begin m_done = 1; m_code = merge(d, s); end
        default: ;
      endcase
    end
    if (q.size() > 0) m_head = q[0];
  endtask

  task automatic check_outputs();
    check("iobus_data", o_iobus_data, m_rd);
    check("log_valid", 32'(o_log_valid), 32'(q.size() > 0));
    check("log_data", o_log_data, m_head);
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("done", 32'(o_done), 32'(m_done));
    check("done_code", o_done_code, m_code);
  endtask

  // One bus cycle: drive, check the combinational hit, clock, update model, compare.
  task automatic cycle(input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d, input logic rdy);
    re = r; we = w; sel = s; addr = a; wdata = d; ready = rdy;
    #1;
    check("hit", 32'(o_hit), 32'((r | w) && (a[31:4] == BASE[31:4])));
    @(posedge clk); #1;
    model_step(r, w, s, a, d, rdy);
    check_outputs();
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s, input logic rdy);
    cycle(1'b0, 1'b1, s, BASE + 32'(off), d, rdy);
  endtask

  task automatic rd(input logic [3:0] off, input logic rdy);
    cycle(1'b1, 1'b0, 4'h0, BASE + 32'(off), 32'h0, rdy);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy);
  endtask

  task automatic do_reset(input logic r);
    rst = 1; re = r; we = 0; sel = 4'h0; addr = BASE + 32'h4; wdata = 0; ready = 0;
    @(posedge clk); #1;
    rst = 0; re = 0;
    model_reset();
    check_outputs();
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [3:0]  sel;
    logic [3:0]  off;
    logic [31:0] wdata;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];
  int   fib[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};

  initial begin
    rst = 1; re = 0; we = 0; sel = 0; addr = 0; wdata = 0; ready = 0;
    model_reset();
    do_reset(1'b0);
    do_reset(1'b0);
    check("rst_iobus_data", o_iobus_data, 32'h0);
    check("rst_log_valid", 32'(o_log_valid), 32'h0);
    check("rst_log_data", o_log_data, 32'h0);

    // Fibonacci stream with the consumer always ready.
    for (int i = 0; i < 10; i++)
      vecs[i] = '{re: 0, we: 1, sel: 4'hF, off: 4'h0, wdata: 32'(fib[i]), ready: 1,
                  exp_valid: 1, exp_data: 32'(fib[i]), exp_rdata: 32'h0};
    vecs[10] = '{re: 0, we: 0, sel: 4'h0, off: 4'h0, wdata: 0, ready: 1,
                 exp_valid: 0, exp_data: 32'd34, exp_rdata: 32'h0};
    vecs[11] = '{re: 1, we: 0, sel: 4'h0, off: 4'hC, wdata: 0, ready: 1,
                 exp_valid: 0, exp_data: 32'd34, exp_rdata: 32'd10};
    vecs[12] = '{re: 1, we: 0, sel: 4'h0, off: 4'h4, wdata: 0, ready: 1,
                 exp_valid: 0, exp_data: 32'd34, exp_rdata: 32'h0000_0004};
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].re, vecs[i].we, vecs[i].sel, BASE + 32'(vecs[i].off), vecs[i].wdata, vecs[i].ready);
      check("vec_valid", 32'(o_log_valid), 32'(vecs[i].exp_valid));
      check("vec_data", o_log_data, vecs[i].exp_data);
      check("vec_rdata", o_iobus_data, vecs[i].exp_rdata);
    end

    // Overflow: 17 writes into a 16-deep FIFO with the consumer stalled.
    do_reset(1'b0);
    for (int i = 1; i <= 17; i++) wr(4'h0, 32'(i), 4'hF, 1'b0);
    rd(4'h4, 1'b0);
    check("ovf_status", o_iobus_data, 32'h0010_0018);
    rd(4'hC, 1'b0);
    check("ovf_total", o_iobus_data, 32'd17);
    for (int k = 1; k <= 16; k++) begin
      check("drain_valid", 32'(o_log_valid), 32'h1);
      check("drain_word", o_log_data, 32'(k));
      idle(1'b1);
    end
    check("drain_empty", 32'(o_log_valid), 32'h0);
    wr(4'h4, 32'h1, 4'hF, 1'b0);
    check("ovf_clear", 32'(o_overflow), 32'h0);

    // Full FIFO: write and pop in the same cycle.
    for (int i = 0; i < 16; i++) wr(4'h0, 32'(200 + i), 4'hF, 1'b0);
    wr(4'h0, 32'hFEED_0001, 4'hF, 1'b1);
    check("full_pp_ovf", 32'(o_overflow), 32'h0);
    rd(4'h4, 1'b0);
    check("full_pp_status", o_iobus_data, 32'h0010_0008);
    for (int k = 0; k < 16; k++) begin
      check("full_pp_word", o_log_data, (k == 15) ? 32'hFEED_0001 : 32'(201 + k));
      idle(1'b1);
    end
    check("full_pp_empty", 32'(o_log_valid), 32'h0);

    // Byte lanes and sel=0 no-op.
    wr(4'h0, 32'hAABB_CCDD, 4'b0101, 1'b0);
    check("lane_merge", o_log_data, 32'h00BB_00DD);
    idle(1'b1);
    wr(4'h0, 32'h1234_5678, 4'b0000, 1'b1);
    check("sel0_valid", 32'(o_log_valid), 32'h0);

    // DONE register and out-of-window read.
    wr(4'h8, 32'h0000_0001, 4'hF, 1'b0);
    check("done_set", 32'(o_done), 32'h1);
    check("done_code1", o_done_code, 32'h1);
    rd(4'h8, 1'b0);
    check("done_read", o_iobus_data, 32'h1);
    re = 1; we = 0; addr = BASE + 32'h20; #1;
    check("oow_hit", 32'(o_hit), 32'h0);
    cycle(1'b1, 1'b0, 4'h0, BASE + 32'h20, 32'h0, 1'b0);
    check("oow_data", o_iobus_data, 32'h0);

    // Reset with words queued and a read in flight.
    for (int i = 0; i < 5; i++) wr(4'h0, 32'(i + 50), 4'hF, 1'b0);
    rd(4'h0, 1'b0);
    check("pre_rst_count", o_iobus_data, 32'd5);
    do_reset(1'b1);
    check("mid_rst_valid", 32'(o_log_valid), 32'h0);
    check("mid_rst_data", o_iobus_data, 32'h0);
    rd(4'h0, 1'b0);
    check("mid_rst_count", o_iobus_data, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 9) == 0) a = $urandom();
        else a = BASE | 32'($urandom_range(0, 15));
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
              a, $urandom(), 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
